io_handshake: RTL

//  Upstream of the control unit. Produces its `sinal` input for the blocking IN/OUT instructions.

---
 rtl/io_pkg.sv | 13 +
 rtl/button_debounce.sv | 43 ++++
 rtl/io_handshake.sv | 106 ++++++++++
 3 files changed

// File: rtl/io_pkg.sv
// Shared types for the IN/OUT operator handshake: FSM states and the latched operation.
package io_pkg;

    typedef enum logic [1:0] {IDLE, WAIT_PRESS, WAIT_RELEASE, ACK} io_state_t;

    typedef enum logic {OP_IO_IN, OP_IO_OUT} io_op_t;

    // IN wins when the control unit flags both operations at once.
    function automatic io_op_t select_op(input logic in_op);
        return in_op ? OP_IO_IN : OP_IO_OUT;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Synchronises and debounces the raw confirm button; press_o pulses for one cycle
// in the cycle the debounced level first reads 1.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw_i,
    output logic level_o,
    output logic press_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_1;
    logic             sync_2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_1  <= 1'b0;
            sync_2  <= 1'b0;
            cnt     <= '0;
            level_o <= 1'b0;
            press_o <= 1'b0;
        end else begin
            sync_1  <= raw_i;
            sync_2  <= sync_1;
            press_o <= 1'b0;
            if (sync_2 == level_o) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level_o <= sync_2;
                press_o <= sync_2;
                cnt     <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/io_handshake.sv
// Stalls the core on IN/OUT until the operator presses and releases the confirm button,
// then returns a one-cycle sinal_o completion pulse to the control unit.
//
// state        | meaning
// IDLE         | no transaction; waiting for stop_i with in_i/out_i
// WAIT_PRESS   | op latched; waiting for a fresh debounced press
// WAIT_RELEASE | pressed (switches captured for IN); waiting for release
// ACK          | sinal_o high for this single cycle
module io_handshake
    import io_pkg::*;
#(
    parameter int DATA_W          = 32,
    parameter int SW_W            = 16,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              stop_i,
    input  logic              in_i,
    input  logic              out_i,
    input  logic              botao_i,
    input  logic [SW_W-1:0]   chaves_i,
    input  logic [DATA_W-1:0] dado_out_i,
    output logic              sinal_o,
    output logic [DATA_W-1:0] dado_in_o,
    output logic [DATA_W-1:0] display_o,
    output logic              display_valid_o,
    output logic              waiting_o
);

    io_state_t state, next_state;
    io_op_t    op_q;
    logic      btn_level;
    logic      btn_press;
    logic      load_op;
    logic      capture_in;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
        .clk     (clk),
        .reset_n (reset_n),
        .raw_i   (botao_i),
        .level_o (btn_level),
        .press_o (btn_press)
    );

    always_comb begin
        next_state = state;
        load_op    = 1'b0;
        capture_in = 1'b0;
        case (state)
            IDLE: begin
                if (stop_i && (in_i || out_i)) begin
                    next_state = WAIT_PRESS;
                    load_op    = 1'b1;
                end
            end
            WAIT_PRESS: begin
                if (!stop_i) begin
                    next_state = IDLE;
                end else if (btn_press) begin
                    next_state = WAIT_RELEASE;
                    capture_in = (op_q == OP_IO_IN);
                end
            end
            WAIT_RELEASE: begin
                if (!stop_i) begin
                    next_state = IDLE;
                end else if (!btn_level) begin
                    next_state = ACK;
                end
            end
            ACK:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs come straight from flops so the control unit never sees decode glitches.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state           <= IDLE;
            op_q            <= OP_IO_IN;
            sinal_o         <= 1'b0;
            waiting_o       <= 1'b0;
            dado_in_o       <= '0;
            display_o       <= '0;
            display_valid_o <= 1'b0;
        end else begin
            state     <= next_state;
            sinal_o   <= (next_state == ACK);
            waiting_o <= (next_state == WAIT_PRESS) || (next_state == WAIT_RELEASE);
            if (load_op) begin
                op_q <= select_op(in_i);
                if (!in_i) begin
                    display_o       <= dado_out_i;
                    display_valid_o <= 1'b1;
                end
            end
            if (capture_in) begin
                dado_in_o <= DATA_W'(chaves_i);
            end
        end
    end

endmodule
